// File: rtl/period_meter_if.sv
// Measurement-side bundle for period_meter: enable and signal in, period/flags out.
interface period_meter_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             out_of_range;
  logic             stall;

  modport master (
    output en, sig_in,
    input  period_out, period_valid, out_of_range, stall
  );

  modport slave (
    input  en, sig_in,
    output period_out, period_valid, out_of_range, stall
  );
endinterface

// File: rtl/period_meter.sv
// Period meter for a slow asynchronous square wave, counted in clk_in cycles.
// Optional build macro PERIOD_AVG_EN reports the 4-period running average instead.
module period_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 60000,
  parameter int MIN_PERIOD = 100,
  parameter int MAX_PERIOD = 50000
) (
  input  logic           clk_in,
  input  logic           reset_n,
  period_meter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  logic             s1, s2, s3;
  logic             edge_det;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             stall_q;
  logic             raw_vld;
  logic [CNT_W-1:0] raw_per;
  logic             raw_oor;
  logic             meas_hit, stall_go;

  function automatic logic range_bad(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(MIN_PERIOD)) || (p > CNT_W'(MAX_PERIOD));
  endfunction

  assign edge_det = s2 & ~s3;
  assign cnt_inc  = cnt + 1'b1;
  assign meas_hit = bus.en && (state == MEASURE) && edge_det;
  // An edge landing on the timeout cycle wins: it is reported as a period.
  assign stall_go = bus.en && (state == MEASURE) && !edge_det &&
                    (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= 1'b0;
      raw_vld <= 1'b0;
      raw_per <= '0;
      raw_oor <= 1'b0;
    end else begin
      raw_vld <= meas_hit;
      if (!bus.en) begin
        state   <= IDLE;
        cnt     <= '0;
        stall_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (edge_det) begin
              state <= MEASURE;
              cnt   <= '0;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              cnt     <= '0;
              raw_per <= cnt_inc;
              raw_oor <= range_bad(cnt_inc);
            end else if (stall_go) begin
              state   <= STALLED;
              stall_q <= 1'b1;
              raw_per <= '0;
              raw_oor <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          STALLED: begin
            if (edge_det) begin
              state   <= MEASURE;
              cnt     <= '0;
              stall_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall = stall_q;

`ifdef PERIOD_AVG_EN
  logic [3:0][CNT_W-1:0] hist;
  logic [CNT_W+1:0]      sum, sum_nxt;
  logic [CNT_W-1:0]      avg_nxt, avg_per;
  logic [2:0]            fill;
  logic                  avg_vld, avg_oor;

  // Unfilled slots are zero, so subtracting hist[3] is harmless during fill.
  assign sum_nxt = sum + (CNT_W+2)'(raw_per) - (CNT_W+2)'(hist[3]);
  assign avg_nxt = sum_nxt[CNT_W+1:2];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hist    <= '0;
      sum     <= '0;
      fill    <= '0;
      avg_vld <= 1'b0;
      avg_per <= '0;
      avg_oor <= 1'b0;
    end else if (!bus.en || stall_go) begin
      hist    <= '0;
      sum     <= '0;
      fill    <= '0;
      avg_vld <= 1'b0;
      if (stall_go) begin
        avg_per <= '0;
        avg_oor <= 1'b1;
      end
    end else if (raw_vld) begin
      hist    <= {hist[2:0], raw_per};
      sum     <= sum_nxt;
      fill    <= (fill == 3'd4) ? fill : fill + 3'd1;
      avg_vld <= (fill >= 3'd3);
      if (fill >= 3'd3) begin
        avg_per <= avg_nxt;
        avg_oor <= range_bad(avg_nxt);
      end
    end else begin
      avg_vld <= 1'b0;
    end
  end

  assign bus.period_out   = avg_per;
  assign bus.out_of_range = avg_oor;
  assign bus.period_valid = avg_vld;
`else
  assign bus.period_out   = raw_per;
  assign bus.out_of_range = raw_oor;
  assign bus.period_valid = raw_vld;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Randomized + directed scoreboard bench for period_meter; expectations come from rise-time gaps.
module tb_period_meter;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4000;
  localparam int MIN_P   = 100;
  localparam int MAX_P   = 2500;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  period_meter_if #(.CNT_W(CNT_W)) bus ();

  period_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int per; int oor; } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: time of last rise, whether a reference edge exists.
  bit armed    = 1'b0;
  int last_rise = 0;
  int win[$];
  int exp_out  = 0;
  int exp_oor  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oor_of(input int p);
    return ((p < MIN_P) || (p > MAX_P)) ? 1 : 0;
  endfunction

  function automatic void model_period(input int p);
    exp_t e;
`ifdef PERIOD_AVG_EN
    int s;
    win.push_back(p);
    if (win.size() > 4) void'(win.pop_front());
    if (win.size() == 4) begin
      s = 0;
      foreach (win[i]) s += win[i];
      e.per = s / 4;
      e.oor = oor_of(e.per);
      q.push_back(e);
      exp_out = e.per;
      exp_oor = e.oor;
    end
`else
    e.per = p;
    e.oor = oor_of(p);
    q.push_back(e);
    exp_out = p;
    exp_oor = e.oor;
`endif
  endfunction

  function automatic void model_clear();
    armed = 1'b0;
    win.delete();
  endfunction

  task automatic do_rise();
    int gap;
    if (armed) begin
      gap = cyc - last_rise;
      if (gap <= TIMEOUT) model_period(gap);
      else begin
        // Meter stalled during this gap; this edge only restarts timing.
        win.delete();
        exp_out = 0;
        exp_oor = 1;
      end
    end
    armed     = 1'b1;
    last_rise = cyc;
    bus.sig_in = 1'b1;
  endtask

  task automatic wave(input int n);
    do_rise();
    repeat (n / 2) @(negedge clk_in);
    bus.sig_in = 1'b0;
    repeat (n - n / 2) @(negedge clk_in);
  endtask

  // Monitor: pop an expectation on every strobe.
  bit prev_v = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_n && bus.period_valid) begin
      check("strobe_not_back_to_back", int'(prev_v), 0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: period_out %0d with no expected period (cycle %0d)",
                 bus.period_out, cyc);
      end else begin
        e = q.pop_front();
        check("period_out", int'(bus.period_out), e.per);
        check("out_of_range", int'(bus.out_of_range), e.oor);
        check("stall_at_strobe", int'(bus.stall), 0);
      end
    end
    prev_v = bus.period_valid;
  end

  initial begin
    int c;
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_period_out", int'(bus.period_out), 0);
    check("rst_valid", int'(bus.period_valid), 0);
    check("rst_oor", int'(bus.out_of_range), 0);
    check("rst_stall", int'(bus.stall), 0);
    reset_n = 1'b1;
    bus.en  = 1'b1;
    repeat (5) @(negedge clk_in);

    // Nominal 1176-cycle wave
    repeat (5) wave(1176);

    // Range limits
    wave(99); wave(100); wave(MAX_P); wave(MAX_P + 1);

    // Edge exactly on the timeout cycle is reported
    wave(TIMEOUT);
    wave(300);

    // Stall and recovery
    do_rise();
    c = cyc;
    repeat (10) @(negedge clk_in);
    bus.sig_in = 1'b0;
    while (cyc < c + 2 + TIMEOUT) @(negedge clk_in);
    check("stall_before_timeout", int'(bus.stall), 0);
    @(negedge clk_in);
    check("stall_at_timeout", int'(bus.stall), 1);
    check("stall_period_out", int'(bus.period_out), 0);
    check("stall_oor", int'(bus.out_of_range), 1);
    repeat (50) @(negedge clk_in);
    do_rise();
    repeat (10) @(negedge clk_in);
    check("stall_cleared", int'(bus.stall), 0);
    repeat (240) @(negedge clk_in);
    bus.sig_in = 1'b0;
    repeat (250) @(negedge clk_in);
    wave(1176); wave(1176);

    // Enable dropped mid-period
    do_rise();
    repeat (588) @(negedge clk_in);
    bus.sig_in = 1'b0;
    repeat (300) @(negedge clk_in);
    bus.en = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_in);
    check("en0_period_hold", int'(bus.period_out), exp_out);
    check("en0_oor_hold", int'(bus.out_of_range), exp_oor);
    check("en0_stall", int'(bus.stall), 0);
    repeat (20) @(negedge clk_in);
    bus.en = 1'b1;
    repeat (100) @(negedge clk_in);
    wave(1176); wave(1176);

    // Async reset mid-period
    do_rise();
    repeat (588) @(negedge clk_in);
    bus.sig_in = 1'b0;
    repeat (300) @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    check("arst_period_out", int'(bus.period_out), 0);
    check("arst_valid", int'(bus.period_valid), 0);
    check("arst_oor", int'(bus.out_of_range), 0);
    check("arst_stall", int'(bus.stall), 0);
    @(negedge clk_in);
    reset_n = 1'b1;
    model_clear();
    exp_out = 0;
    exp_oor = 0;
    repeat (100) @(negedge clk_in);
    wave(700); wave(700);

`ifdef PERIOD_AVG_EN
    wave(1000); wave(1000); wave(1000); wave(1004); wave(1004);
`endif

    // Randomized periods, one long gap to provoke an incidental stall
    for (int i = 0; i < 16; i++) begin
      if (i == 9) wave(TIMEOUT + 300);
      else        wave($urandom_range(2, 2600));
    end

    do_rise();
    repeat (12) @(negedge clk_in);
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
